wave_decode_arbiter: RTL
========================

# wave_decode_arbiter

Sequencer between the per-wavefront instruction buffer and the decode stage. Each cycle it picks one wavefront with a buffered instruction word by round-robin, reads that word from the buffer and presents it to decode on the `wave_instr_*` interface. For 64-bit instructions it honours decode's second-half request by forcing the next word from the same wavefront ahead of all others.

## Interface
- `NUM_WF`, 40: number of wavefront slots. Must be ≤ 64.
- `clk` input 1: clock.
- `rst` input 1: asynchronous, active-high reset.
- `wf_ready` input NUM_WF: bit i=1 means the buffer holds at least one word for wfid i.
- `wf_flush` input NUM_WF: bit i=1 kills wfid i this cycle (halt or branch redirect).
- `issue_stall` input 1: back-pressure from issue; blocks first words only.
- `buf_rd_en` output 1: combinational buffer pop strobe.
- `buf_rd_wfid` output 6: combinational slot being popped.
- `buf_rd_instr` input 32: word at the head of `buf_rd_wfid`, valid in the same cycle.
- `buf_rd_pc` input 32: PC of that word.
- `wave_ins_half_rqd` input 1: decode requests the second word.
- `wave_ins_half_wfid` input 6: wavefront that owns the second-word request.
- `wave_instr_valid` output 1: registered; word is valid for exactly one cycle.
- `wave_wfid` output 6: registered wfid of the presented word.
- `wave_instr` output 32: registered instruction word.
- `wave_instr_pc` output 32: registered PC of the word.
- `half_pending` output 1: high in states GAP and HALF.
- `protocol_err` output 1: sticky; cleared only by reset.

## Operation
- FSM states: ARB, GAP, HALF.
- State register `last_wfid` (6 bits).
- Round-robin pointer `rr_ptr`, range 0..NUM_WF-1.
- ARB:
  - Eligible set = `wf_ready & ~wf_flush`.
  - If `issue_stall`=0 and the set is non-empty, grant the first eligible slot at or after `rr_ptr`, wrapping through NUM_WF-1 to 0.
  - On grant: assert `buf_rd_en` with `buf_rd_wfid` = grant. Register `buf_rd_instr`/`buf_rd_pc` into the outputs with `wave_instr_valid`=1. Set `last_wfid` = grant. Set `rr_ptr` = (grant+1) mod NUM_WF. Go to GAP.
  - Without a grant, stay in ARB.
  - If `wave_ins_half_rqd`=1 while in ARB, set `protocol_err`.
- GAP (no pop this cycle): sample `wave_ins_half_rqd`.
  - If `wf_flush[last_wfid]`=1, go to ARB. The request is ignored.
  - Else if request=0, go to ARB.
  - Else if `wave_ins_half_wfid` ≠ `last_wfid`, set `protocol_err` and go to ARB.
  - Else if `wf_ready[last_wfid]`=1, pop `last_wfid` as the second word, present it, and go to ARB.
  - Else go to HALF.
- HALF: stall all other wavefronts.
  - If `wf_flush[last_wfid]`, go to ARB.
  - Else if `wf_ready[last_wfid]`, pop and present the second word, then go to ARB.
  - Else stay in HALF.
- Second-word pops ignore `issue_stall` and do not move `rr_ptr`.
- `buf_rd_en` is never asserted for a flushed slot.

## Timing
- Reset values: state ARB, `rr_ptr`=0, `last_wfid`=0, `wave_instr_valid`=0, `wave_wfid`=0, `wave_instr`=0, `wave_instr_pc`=0, `protocol_err`=0.
- `buf_rd_en`, `half_pending`: 0 during reset.
- Latency: pop in cycle t → `wave_instr_valid`=1 in cycle t+1.
- Decode raises `wave_ins_half_rqd` in the cycle after it receives the first word; that is the arbiter's GAP cycle.
- Best-case cadence:
  - 32-bit instructions: one word every 2 cycles (ARB, GAP, ARB, ...).
  - 64-bit instruction: first word at t+1 and second word at t+2, back-to-back.
- `wave_instr_valid`=0 in every cycle without a preceding pop. The data outputs hold their last values.
- Simultaneous `wf_flush[i]` and `wf_ready[i]` in ARB: slot i is not eligible.
- Asynchronous reset mid-HALF: returns to ARB immediately. The pending half is dropped.

## Test plan
- Round-robin:
  - Stimulus: `wf_ready` bits 3, 7 and 39 held high, no half requests.
  - Required: pops in order 3, 7, 39, 3, …, one every 2 cycles. `wave_wfid` matches each pop one cycle later.
- Literal constant:
  - Stimulus: grant wfid 37 with word 0xBE82_07FF. Decode raises half_rqd with wfid 37 in GAP, and `wf_ready[37]`=1.
  - Required: second pop of 37 in GAP. `wave_instr` = second word at t+2. `rr_ptr` = 38.
- Second word not buffered:
  - Stimulus: as the literal case, but `wf_ready[37]`=0 for 3 cycles while wfid 5 is ready.
  - Required: state HALF, no pops, `half_pending`=1. wfid 37 is popped on the first ready cycle; wfid 5 follows afterward.
- Stall:
  - Stimulus: `issue_stall`=1 with a pending half request for wfid 27.
  - Required: the second word of 27 is still issued. No first word is issued until the stall drops.
- Flush and error:
  - Stimulus: `wf_flush[27]` asserted in HALF.
  - Required: return to ARB with no pop of 27.
  - Stimulus: a separate run with half_rqd wfid 9 when `last_wfid`=0.
  - Required: `protocol_err`=1, which stays set until `rst`.
- Reset:
  - Stimulus: `rst` pulsed mid-HALF.
  - Required: all outputs 0 during reset. After release, the first grant starts from wfid 0.

Source files
------------

// File: rtl/wave_decode_arbiter.sv
// Round-robin sequencer from the per-wavefront instruction buffer to decode.
// Holds the owning wavefront after a first word so 64-bit instructions get their second half.
module wave_decode_arbiter #(
    parameter int NUM_WF = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WF-1:0] wf_ready,
    input  logic [NUM_WF-1:0] wf_flush,
    input  logic              issue_stall,
    output logic              buf_rd_en,
    output logic [5:0]        buf_rd_wfid,
    input  logic [31:0]       buf_rd_instr,
    input  logic [31:0]       buf_rd_pc,
    input  logic              wave_ins_half_rqd,
    input  logic [5:0]        wave_ins_half_wfid,
    output logic              wave_instr_valid,
    output logic [5:0]        wave_wfid,
    output logic [31:0]       wave_instr,
    output logic [31:0]       wave_instr_pc,
    output logic              half_pending,
    output logic              protocol_err
);

    typedef enum logic [1:0] {ARB, GAP, HALF} state_t;

    state_t            state, state_next;
    logic [5:0]        rr_ptr, last_wfid;
    logic [NUM_WF-1:0] eligible;
    logic              grant_found;
    logic [5:0]        grant_wfid;
    logic [6:0]        scan_idx;
    logic              first_pop;
    logic              err_set;
    logic              last_ready, last_flush;

    assign eligible     = wf_ready & ~wf_flush;
    assign last_ready   = wf_ready[last_wfid];
    assign last_flush   = wf_flush[last_wfid];
    assign half_pending = (state != ARB);

    // Scan from rr_ptr upward, wrapping past NUM_WF-1, and keep the first eligible slot.
    always_comb begin
        grant_found = 1'b0;
        grant_wfid  = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_WF; k++) begin
            scan_idx = {1'b0, rr_ptr} + 7'(k);
            if (scan_idx >= 7'(NUM_WF))
                scan_idx = scan_idx - 7'(NUM_WF);
            if (!grant_found && eligible[scan_idx[5:0]]) begin
                grant_found = 1'b1;
                grant_wfid  = scan_idx[5:0];
            end
        end
    end

    always_comb begin
        state_next  = state;
        buf_rd_en   = 1'b0;
        buf_rd_wfid = '0;
        first_pop   = 1'b0;
        err_set     = 1'b0;
        case (state)
            ARB: begin
                if (wave_ins_half_rqd)
                    err_set = 1'b1;
                if (!issue_stall && grant_found) begin
                    buf_rd_en   = 1'b1;
                    buf_rd_wfid = grant_wfid;
                    first_pop   = 1'b1;
                    state_next  = GAP;
                end
            end
            GAP: begin
                if (last_flush || !wave_ins_half_rqd) begin
                    state_next = ARB;
                end else if (wave_ins_half_wfid != last_wfid) begin
                    err_set    = 1'b1;
                    state_next = ARB;
                end else if (last_ready) begin
                    buf_rd_en   = 1'b1;
                    buf_rd_wfid = last_wfid;
                    state_next  = ARB;
                end else begin
                    state_next = HALF;
                end
            end
            HALF: begin
                if (last_flush) begin
                    state_next = ARB;
                end else if (last_ready) begin
                    buf_rd_en   = 1'b1;
                    buf_rd_wfid = last_wfid;
                    state_next  = ARB;
                end
            end
            default: state_next = ARB;
        endcase
        // The pop strobe feeds the buffer directly, so it must stay quiet while reset is held.
        if (rst) begin
            buf_rd_en   = 1'b0;
            buf_rd_wfid = '0;
            first_pop   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ARB;
        else
            state <= state_next;
    end

    // Second-word pops reuse last_wfid and leave the round-robin pointer alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr           <= '0;
            last_wfid        <= '0;
            wave_instr_valid <= 1'b0;
            wave_wfid        <= '0;
            wave_instr       <= '0;
            wave_instr_pc    <= '0;
            protocol_err     <= 1'b0;
        end else begin
            wave_instr_valid <= buf_rd_en;
            if (buf_rd_en) begin
                wave_wfid     <= buf_rd_wfid;
                wave_instr    <= buf_rd_instr;
                wave_instr_pc <= buf_rd_pc;
            end
            if (first_pop) begin
                last_wfid <= grant_wfid;
                rr_ptr    <= (grant_wfid == 6'(NUM_WF - 1)) ? 6'd0 : grant_wfid + 6'd1;
            end
            if (err_set)
                protocol_err <= 1'b1;
        end
    end

endmodule
